clk_gen_ctrl: RTL and testbench

- Synthesizable programmable clock/pulse generator controller.
- Derives an output waveform `clk_out` from the system clock `clk` using configurable period, high time and start phase, all in clk cycles.
- Configuration arrives over a valid/ready interface into shadow registers. Updates apply only at period boundaries, so `clk_out` never glitches.
- Replaces behavioural delay-based clock generation in benches and SoC-level pulse sources.

---
 rtl/clk_gen_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clk_gen_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl: programmable clock / pulse generator.
// Produces clk_out with a configurable period, high time and start phase,
// all counted in clk cycles. Config words are accepted over valid/ready and
// are applied only at period boundaries, so clk_out never glitches.
// en is registered once before the IDLE start decision, so a start sampled
// at edge k gives the first clk_out rise at edge k+phase+1.
// All outputs are registered from the next-state decode, so each output
// lines up exactly with the state it describes.
module clk_gen_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             clk_out,
  output logic             busy,
  output logic             period_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{period: CNT_W'(2), high: CNT_W'(1), phase: '0};

  state_t           state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt;
  cfg_t             act, n_act;
  cfg_t             pend, n_pend;
  logic             pend_vld, n_pend_vld;
  logic             en_q;

  cfg_t             in_cfg;
  cfg_t             start_cfg;
  cfg_t             bnd_cfg;
  logic             xfer;
  logic             legal;
  logic             take;

  // Handshake and legality of the incoming word.
  assign in_cfg = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
  assign xfer   = cfg_valid && cfg_ready;
  assign legal  = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
                  (cfg_high < cfg_period);
  assign take   = xfer && legal;

  // Config used when leaving IDLE: a word accepted in the same cycle wins.
  assign start_cfg = take ? in_cfg : act;

  // Config for the period after a boundary: a word accepted in the boundary
  // cycle itself wins, then any pending shadow, else the active one.
  assign bnd_cfg = take ? in_cfg : (pend_vld ? pend : act);

  // Next-state decode: FSM transitions, counter reloads and shadow updates.
  always_comb begin
    n_state    = state;
    n_cnt      = cnt;
    n_act      = act;
    n_pend     = pend;
    n_pend_vld = pend_vld;
    case (state)
      IDLE: begin
        // Nothing is running, so a legal word goes straight to active.
        if (take) n_act = in_cfg;
        if (en_q) begin
          if (start_cfg.phase != '0) begin
            n_state = PHASE;
            n_cnt   = start_cfg.phase - CNT_W'(1);
          end else begin
            n_state = HIGH;
            n_cnt   = start_cfg.high - CNT_W'(1);
          end
        end
      end
      PHASE: begin
        if (take) begin
          n_pend     = in_cfg;
          n_pend_vld = 1'b1;
        end
        if (!en) begin
          // Abort before any high output; a pending word can go live now
          // since no waveform is in flight, which also reopens cfg_ready.
          n_state    = IDLE;
          n_act      = pend_vld ? pend : act;
          n_pend_vld = 1'b0;
        end else if (cnt == '0) begin
          n_state = HIGH;
          n_cnt   = act.high - CNT_W'(1);
        end else begin
          n_cnt = cnt - CNT_W'(1);
        end
      end
      HIGH: begin
        if (take) begin
          n_pend     = in_cfg;
          n_pend_vld = 1'b1;
        end
        if (cnt == '0) begin
          // Active config is validated, so period-high-1 cannot wrap.
          n_state = LOW;
          n_cnt   = act.period - act.high - CNT_W'(1);
        end else begin
          n_cnt = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          // Period boundary: the only place the live config may change.
          n_act      = bnd_cfg;
          n_pend_vld = 1'b0;
          if (en) begin
            n_state = HIGH;
            n_cnt   = bnd_cfg.high - CNT_W'(1);
          end else begin
            n_state = IDLE;
          end
        end else begin
          if (take) begin
            n_pend     = in_cfg;
            n_pend_vld = 1'b1;
          end
          n_cnt = cnt - CNT_W'(1);
        end
      end
      default: n_state = IDLE;
    endcase
  end

  // State, config shadows and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      act         <= CFG_RST;
      pend        <= CFG_RST;
      pend_vld    <= 1'b0;
      en_q        <= 1'b0;
      clk_out     <= 1'b0;
      busy        <= 1'b0;
      period_done <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      act         <= n_act;
      pend        <= n_pend;
      pend_vld    <= n_pend_vld;
      en_q        <= en;
      clk_out     <= (n_state == HIGH);
      busy        <= (n_state != IDLE);
      period_done <= (n_state == LOW) && (n_cnt == '0);
      cfg_err     <= xfer && !legal;
      cfg_ready   <= !n_pend_vld;
    end
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// tb_clk_gen_ctrl: directed plus random stimulus against a position-in-period
// reference model of the clock generator.
module tb_clk_gen_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic             clk_out;
  logic             busy;
  logic             period_done;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  clk_gen_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .clk_out(clk_out), .busy(busy), .period_done(period_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=off, 1=start delay, 2=running; pos is the cycle
  // index inside the current period, so clk_out = pos < high.
  int m_mode, m_pos, m_ph_left;
  int a_p, a_h, a_ph, p_p, p_h, p_ph;
  bit m_pend, m_enq;
  bit e_clk, e_pd, e_busy, e_rdy, e_err;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_ph_left = 0;
    a_p = 2; a_h = 1; a_ph = 0;
    m_pend = 0; m_enq = 0;
    e_clk = 0; e_pd = 0; e_busy = 0; e_rdy = 1; e_err = 0;
  endfunction

  function automatic void model_step();
    bit xfer, legal, take, bnd;
    int cp, ch, cph;
    cp = int'(cfg_period); ch = int'(cfg_high); cph = int'(cfg_phase);
    xfer  = cfg_valid && e_rdy;
    legal = (cp >= 2) && (ch >= 1) && (ch < cp);
    take  = xfer && legal;
    e_err = xfer && !legal;
    if (m_mode == 0) begin
      if (take) begin a_p = cp; a_h = ch; a_ph = cph; end
      if (m_enq) begin
        if (a_ph > 0) begin m_mode = 1; m_ph_left = a_ph; end
        else begin m_mode = 2; m_pos = 0; end
      end
    end else if (m_mode == 1) begin
      if (take) begin p_p = cp; p_h = ch; p_ph = cph; m_pend = 1; end
      if (!en) begin
        if (m_pend) begin a_p = p_p; a_h = p_h; a_ph = p_ph; end
        m_pend = 0;
        m_mode = 0;
      end else if (m_ph_left == 1) begin
        m_mode = 2; m_pos = 0;
      end else begin
        m_ph_left--;
      end
    end else begin
      bnd = (m_pos == a_p - 1);
      if (bnd) begin
        if (take) begin a_p = cp; a_h = ch; a_ph = cph; end
        else if (m_pend) begin a_p = p_p; a_h = p_h; a_ph = p_ph; end
        m_pend = 0;
        if (en) m_pos = 0;
        else m_mode = 0;
      end else begin
        if (take) begin p_p = cp; p_h = ch; p_ph = cph; m_pend = 1; end
        m_pos++;
      end
    end
    m_enq  = en;
    e_clk  = (m_mode == 2) && (m_pos < a_h);
    e_pd   = (m_mode == 2) && (m_pos == a_p - 1);
    e_busy = (m_mode != 0);
    e_rdy  = !m_pend;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("period_done", 32'(period_done), 32'(e_pd));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
  endtask

  // One clock: model advances with the DUT edge, outputs compared mid-cycle.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic send_cfg(input int p, input int h, input int ph);
    cfg_period = CNT_W'(p); cfg_high = CNT_W'(h); cfg_phase = CNT_W'(ph);
    cfg_valid  = 1'b1;
    cyc();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_high(input string tag);
    for (int i = 0; i < 60 && !e_clk; i++) cyc();
    chk(tag, 32'(clk_out), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && e_busy; i++) cyc();
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    model_reset();
    #12;
    // Reset defaults.
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_period_done", 32'(period_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Default 2/1/0 waveform.
    en = 1'b1;
    cyc(10);
    en = 1'b0;
    wait_idle("idle_after_default");

    // 10/5/3 programmed in IDLE.
    send_cfg(10, 5, 3);
    cyc();
    en = 1'b1;
    cyc(32);

    // Mid-HIGH update to 4/1/0: applied at the next boundary.
    wait_high("reach_high_10_5");
    cyc(2);
    send_cfg(4, 1, 0);
    chk("ready_low_pending", 32'(cfg_ready), 32'd0);
    cyc(24);

    // Illegal words are rejected.
    send_cfg(1, 1, 0);
    cyc(3);
    send_cfg(8, 8, 0);
    cyc(3);
    send_cfg(6, 0, 0);
    cyc(6);

    // Drop en during HIGH of 6/2.
    en = 1'b0;
    wait_idle("idle_before_6_2");
    send_cfg(6, 2, 0);
    en = 1'b1;
    wait_high("reach_high_6_2");
    en = 1'b0;
    cyc(10);
    chk("idle_after_6_2", 32'(busy), 32'd0);

    // Drop en during PHASE with phase=5.
    send_cfg(6, 2, 5);
    en = 1'b1;
    cyc(4);
    en = 1'b0;
    cyc(6);
    chk("idle_after_phase_abort", 32'(busy), 32'd0);

    // Random traffic, including illegal and boundary-coincident configs.
    for (int i = 0; i < 600; i++) begin
      en         = ($urandom_range(0, 9) < 8);
      cfg_valid  = ($urandom_range(0, 9) < 2);
      cfg_period = CNT_W'($urandom_range(0, 12));
      cfg_high   = CNT_W'($urandom_range(0, 12));
      cfg_phase  = CNT_W'($urandom_range(0, 4));
      cyc();
    end
    cfg_valid = 1'b0;

    // Asynchronous reset in the middle of a high phase.
    en = 1'b1;
    send_cfg(12, 6, 0);
    wait_high("reach_high_pre_reset");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_clk_out", 32'(clk_out), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
